// File: rtl/feature_map_collector.sv
// feature_map_collector
//   Stores one frame of pooled pixels in raster order, then streams the
//   frame out over a valid/ready interface before accepting the next frame.
//
//   Ports
//     clk, reset      rising-edge clock, synchronous active-high reset
//     clk_en          global enable; when low every register and the buffer hold
//     input_data      pooled pixel, channel 0 in the MSBs
//     valid           one pixel per high cycle (honoured only while collecting)
//     out_data        readout pixel
//     out_valid       out_data holds a pixel
//     out_ready       consumer accepts out_data this cycle
//     out_last        high with the final pixel of the frame
//     frame_done      one-cycle pulse after the last pixel of the frame is stored
//     busy            high unless collecting with nothing yet stored
//     overflow        (only with FMAP_OVERFLOW_DETECT_EN) sticky flag, set when a
//                     pixel arrives while the buffer is full or being read out
//
//   Optional feature macro: FMAP_OVERFLOW_DETECT_EN
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   COLLECT  | writing incoming pixels at the write pointer
//   FULL     | frame stored, one cycle before readout begins
//   READOUT  | streaming buffer contents with a one-cycle read latency
module feature_map_collector #(
    parameter int D_WIDTH      = 8,
    parameter int CHANNELS     = 3,
    parameter int IMAGE_WIDTH  = 63,
    parameter int IMAGE_HEIGHT = 31
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clk_en,
    input  logic [CHANNELS*D_WIDTH-1:0]  input_data,
    input  logic                         valid,
    output logic [CHANNELS*D_WIDTH-1:0]  out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic                         frame_done,
`ifdef FMAP_OVERFLOW_DETECT_EN
    output logic                         overflow,
`endif
    output logic                         busy
);

    localparam int DW    = CHANNELS * D_WIDTH;
    localparam int DEPTH = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_FULL    = 2'd1,
        S_READOUT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    // Set once the last address has been fetched, so the read pointer never wraps.
    logic            rd_done_q, rd_done_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;
    logic            frame_done_q, frame_done_d;
    logic            mem_we;
    logic [DW-1:0]   rd_word;

    logic [DW-1:0]   mem [DEPTH];

    // Buffer is never cleared; writes are suppressed while reset is asserted.
    always_ff @(posedge clk) begin
        if (!reset && clk_en && mem_we) begin
            mem[wr_ptr_q] <= input_data;
        end
    end

    assign rd_word = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_COLLECT;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rd_done_q    <= 1'b0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else if (clk_en) begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_done_q    <= rd_done_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        rd_done_d    = rd_done_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        frame_done_d = 1'b0;
        mem_we       = 1'b0;

        case (state_q)
            S_COLLECT: begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                if (valid) begin
                    mem_we = 1'b1;
                    if (wr_ptr_q == LAST_ADDR) begin
                        wr_ptr_d     = '0;
                        state_d      = S_FULL;
                        frame_done_d = 1'b1;
                    end else begin
                        wr_ptr_d = wr_ptr_q + AW'(1);
                    end
                end
            end

            S_FULL: begin
                state_d     = S_READOUT;
                rd_ptr_d    = '0;
                rd_done_d   = 1'b0;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end

            S_READOUT: begin
                if (out_valid_q && out_ready && out_last_q) begin
                    state_d     = S_COLLECT;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    wr_ptr_d    = '0;
                    rd_ptr_d    = '0;
                    rd_done_d   = 1'b0;
                end else if (!out_valid_q || out_ready) begin
                    // Output register is free (or being emptied): fetch the next word.
                    if (!rd_done_q) begin
                        out_data_d  = rd_word;
                        out_valid_d = 1'b1;
                        out_last_d  = (rd_ptr_q == LAST_ADDR);
                        if (rd_ptr_q == LAST_ADDR) begin
                            rd_done_d = 1'b1;
                        end else begin
                            rd_ptr_d = rd_ptr_q + AW'(1);
                        end
                    end else begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end
                end
            end

            default: begin
                state_d = S_COLLECT;
            end
        endcase
    end

`ifdef FMAP_OVERFLOW_DETECT_EN
    logic overflow_q, overflow_d;

    always_comb begin
        overflow_d = overflow_q | (valid && (state_q != S_COLLECT));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (clk_en) begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`endif

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != S_COLLECT) || (wr_ptr_q != '0);

endmodule

// File: tb/tb_feature_map_collector.sv
// Directed bench for feature_map_collector with a 4x2 frame of 3x8-bit pixels.
module tb_feature_map_collector;

    logic        clk;
    logic        reset;
    logic        clk_en;
    logic [23:0] input_data;
    logic        valid;
    logic [23:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        frame_done;
    logic        busy;
`ifdef FMAP_OVERFLOW_DETECT_EN
    logic        overflow;
`endif

    int checks = 0;
    int errors = 0;

    logic [23:0] got_data [8];
    logic        got_last [8];
    int          n_got;

    feature_map_collector #(
        .D_WIDTH(8),
        .CHANNELS(3),
        .IMAGE_WIDTH(4),
        .IMAGE_HEIGHT(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .clk_en(clk_en),
        .input_data(input_data),
        .valid(valid),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last(out_last),
        .frame_done(frame_done),
`ifdef FMAP_OVERFLOW_DETECT_EN
        .overflow(overflow),
`endif
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        valid = 1'b0;
        step();
        reset = 1'b0;
    endtask

    // Writes 8 pixels {3{b+i}}; reports frame_done seen before the 8th write
    // and the frame_done value right after it.
    task automatic write_frame(input logic [7:0] b, output int fd_early, output logic fd_end);
        logic [7:0] px;
        fd_early = 0;
        for (int i = 0; i < 8; i++) begin
            px = b + 8'(i);
            input_data = {px, px, px};
            valid = 1'b1;
            step();
            if (i < 7 && frame_done) fd_early++;
        end
        valid = 1'b0;
        fd_end = frame_done;
    endtask

    // Accepts every pixel with out_ready=1 and records it, bounded in cycles.
    task automatic capture_frame();
        out_ready = 1'b1;
        n_got = 0;
        for (int c = 0; c < 60 && n_got < 8; c++) begin
            if (out_valid) begin
                got_data[n_got] = out_data;
                got_last[n_got] = out_last;
                n_got++;
            end
            step();
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid actual=%b expected=0", out_valid); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last actual=%b expected=0", out_last); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done actual=%b expected=0", frame_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy actual=%b expected=0", busy); end
    endtask

    task automatic test_basic();
        int fde;
        logic fdend;
        logic [7:0] e;
        do_reset();
        write_frame(8'h00, fde, fdend);
        checks++; if (fde !== 0) begin errors++; $display("FAIL basic_fd_early actual=%0d expected=0", fde); end
        checks++; if (fdend !== 1'b1) begin errors++; $display("FAIL basic_fd_pulse actual=%b expected=1", fdend); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_full_out_valid actual=%b expected=0", out_valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_full_busy actual=%b expected=1", busy); end
        step();
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL basic_fd_once actual=%b expected=0", frame_done); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_readout_latency actual=%b expected=0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b1 || out_data !== 24'h000000) begin errors++; $display("FAIL basic_first_pixel actual=%b/%h expected=1/000000", out_valid, out_data); end
        capture_frame();
        checks++; if (n_got !== 8) begin errors++; $display("FAIL basic_count actual=%0d expected=8", n_got); end
        for (int i = 0; i < 8; i++) begin
            e = 8'(i);
            checks++; if (got_data[i] !== {e, e, e}) begin errors++; $display("FAIL basic_data[%0d] actual=%h expected=%h", i, got_data[i], {e, e, e}); end
            checks++; if (got_last[i] !== (i == 7)) begin errors++; $display("FAIL basic_last[%0d] actual=%b expected=%b", i, got_last[i], (i == 7)); end
        end
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_back_to_collect actual=%b/%b expected=0/0", out_valid, busy); end
    endtask

    task automatic test_toggle_valid();
        int fd_count;
        int fd_at;
        logic [7:0] e;
        do_reset();
        fd_count = 0;
        fd_at = -1;
        for (int c = 0; c < 16; c++) begin
            if (c % 2 == 0) begin
                e = 8'h10 + 8'(c / 2);
                input_data = {e, e, e};
                valid = 1'b1;
            end else begin
                valid = 1'b0;
            end
            step();
            if (frame_done) begin
                fd_count++;
                fd_at = c;
            end
        end
        valid = 1'b0;
        checks++; if (fd_count !== 1) begin errors++; $display("FAIL toggle_fd_count actual=%0d expected=1", fd_count); end
        checks++; if (fd_at !== 14) begin errors++; $display("FAIL toggle_fd_cycle actual=%0d expected=14", fd_at); end
        capture_frame();
        checks++; if (n_got !== 8) begin errors++; $display("FAIL toggle_count actual=%0d expected=8", n_got); end
        for (int i = 0; i < 8; i++) begin
            e = 8'h10 + 8'(i);
            checks++; if (got_data[i] !== {e, e, e}) begin errors++; $display("FAIL toggle_data[%0d] actual=%h expected=%h", i, got_data[i], {e, e, e}); end
        end
    endtask

    task automatic test_backpressure();
        int fde;
        logic fdend;
        int stall;
        logic [7:0] e;
        do_reset();
        write_frame(8'h00, fde, fdend);
        out_ready = 1'b1;
        n_got = 0;
        stall = 0;
        for (int c = 0; c < 60 && n_got < 8; c++) begin
            if (out_valid) begin
                if (n_got == 2 && stall < 3) begin
                    checks++; if (out_data !== 24'h020202 || out_last !== 1'b0) begin errors++; $display("FAIL bp_hold[%0d] actual=%h/%b expected=020202/0", stall, out_data, out_last); end
                    out_ready = 1'b0;
                    stall++;
                end else begin
                    out_ready = 1'b1;
                    got_data[n_got] = out_data;
                    got_last[n_got] = out_last;
                    n_got++;
                end
            end
            step();
        end
        out_ready = 1'b1;
        checks++; if (stall !== 3) begin errors++; $display("FAIL bp_stall_cycles actual=%0d expected=3", stall); end
        checks++; if (n_got !== 8) begin errors++; $display("FAIL bp_count actual=%0d expected=8", n_got); end
        for (int i = 0; i < 8; i++) begin
            e = 8'(i);
            checks++; if (got_data[i] !== {e, e, e}) begin errors++; $display("FAIL bp_data[%0d] actual=%h expected=%h", i, got_data[i], {e, e, e}); end
        end
        checks++; if (got_last[7] !== 1'b1) begin errors++; $display("FAIL bp_last actual=%b expected=1", got_last[7]); end
    endtask

    task automatic test_reset_midframe();
        int fde;
        logic fdend;
        logic [7:0] e;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            e = 8'hA0 + 8'(i);
            input_data = {e, e, e};
            valid = 1'b1;
            step();
        end
        valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before actual=%b expected=1", busy); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL midrst_outputs actual=%b/%b/%b expected=0/0/0", out_valid, busy, frame_done); end
        write_frame(8'hB0, fde, fdend);
        checks++; if (fde !== 0 || fdend !== 1'b1) begin errors++; $display("FAIL midrst_fd actual=%0d/%b expected=0/1", fde, fdend); end
        capture_frame();
        checks++; if (n_got !== 8) begin errors++; $display("FAIL midrst_count actual=%0d expected=8", n_got); end
        for (int i = 0; i < 8; i++) begin
            e = 8'hB0 + 8'(i);
            checks++; if (got_data[i] !== {e, e, e}) begin errors++; $display("FAIL midrst_data[%0d] actual=%h expected=%h", i, got_data[i], {e, e, e}); end
        end
    endtask

    task automatic test_clk_en();
        int fde;
        logic fdend;
        logic frozen;
        logic [7:0] e;
        do_reset();
        write_frame(8'h40, fde, fdend);
        out_ready = 1'b1;
        n_got = 0;
        frozen = 1'b0;
        for (int c = 0; c < 60 && n_got < 8; c++) begin
            if (out_valid) begin
                if (n_got == 3 && !frozen) begin
                    clk_en = 1'b0;
                    for (int k = 0; k < 4; k++) begin
                        step();
                        checks++; if (out_data !== 24'h434343 || out_valid !== 1'b1 || out_last !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL clken_frozen[%0d] actual=%h/%b/%b/%b expected=434343/1/0/1", k, out_data, out_valid, out_last, busy); end
                    end
                    clk_en = 1'b1;
                    frozen = 1'b1;
                end
                got_data[n_got] = out_data;
                got_last[n_got] = out_last;
                n_got++;
            end
            step();
        end
        checks++; if (n_got !== 8) begin errors++; $display("FAIL clken_count actual=%0d expected=8", n_got); end
        for (int i = 0; i < 8; i++) begin
            e = 8'h40 + 8'(i);
            checks++; if (got_data[i] !== {e, e, e}) begin errors++; $display("FAIL clken_data[%0d] actual=%h expected=%h", i, got_data[i], {e, e, e}); end
        end
    endtask

    task automatic test_ignore_valid();
        int fde;
        logic fdend;
        logic [7:0] e;
        do_reset();
        write_frame(8'h60, fde, fdend);
`ifdef FMAP_OVERFLOW_DETECT_EN
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear actual=%b expected=0", overflow); end
`endif
        // Drive junk from the FULL cycle through the whole readout.
        input_data = 24'hFFFFFF;
        valid = 1'b1;
        capture_frame();
        valid = 1'b0;
        checks++; if (n_got !== 8) begin errors++; $display("FAIL ign_count actual=%0d expected=8", n_got); end
        for (int i = 0; i < 8; i++) begin
            e = 8'h60 + 8'(i);
            checks++; if (got_data[i] !== {e, e, e}) begin errors++; $display("FAIL ign_data[%0d] actual=%h expected=%h", i, got_data[i], {e, e, e}); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_wr_ptr_zero actual=%b expected=0", busy); end
`ifdef FMAP_OVERFLOW_DETECT_EN
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set actual=%b expected=1", overflow); end
`endif
        write_frame(8'h70, fde, fdend);
        checks++; if (fde !== 0 || fdend !== 1'b1) begin errors++; $display("FAIL ign_next_fd actual=%0d/%b expected=0/1", fde, fdend); end
        capture_frame();
        for (int i = 0; i < 8; i++) begin
            e = 8'h70 + 8'(i);
            checks++; if (got_data[i] !== {e, e, e}) begin errors++; $display("FAIL ign_next_data[%0d] actual=%h expected=%h", i, got_data[i], {e, e, e}); end
        end
`ifdef FMAP_OVERFLOW_DETECT_EN
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky actual=%b expected=1", overflow); end
        do_reset();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_reset actual=%b expected=0", overflow); end
`endif
    endtask

    initial begin
        reset = 1'b1;
        clk_en = 1'b1;
        valid = 1'b0;
        input_data = '0;
        out_ready = 1'b1;
        test_reset();
        test_basic();
        test_toggle_valid();
        test_backpressure();
        test_reset_midframe();
        test_clk_en();
        test_ignore_valid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
